// File: rtl/mips_mc_ctrl_pkg.sv
// Purpose: shared encodings for the multicycle MIPS control slice (states, opcodes, ALU selects, trap causes).
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Ports: none; imported by mips_mc_ctrl_if, mips_alu_dec and mips_mc_ctrl.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_EXC    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [3:0] ALUSEL_ADD  = 4'b0010;
  localparam logic [3:0] ALUSEL_SUB  = 4'b0110;
  localparam logic [3:0] ALUSEL_ZERO = 4'b1111;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_ILL  = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_VEC    = 2'b11;

  // Only the signed R-type forms may raise an overflow trap.
  function automatic logic fn_signed(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB);
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Purpose: bundles IR fields, ALU flags and datapath controls between the control FSM and the datapath.
// Latency: n/a (wires only).
// Backpressure: none; the datapath follows the control outputs every cycle.
// Ports: master = control FSM (drives controls, reads op/funct/flags); slave = datapath (the reverse).
interface mips_mc_ctrl_if;
  import mips_ctrl_pkg::*;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic [3:0] alusel;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       exc;
  logic [1:0] exc_cause;
  logic [3:0] state_o;

  modport master (
    input  op, funct, zero, overflow,
    output alusel, alusrca, alusrcb, iord, memwrite, irwrite, regwrite,
           regdst, memtoreg, pcsrc, pcen, exc, exc_cause, state_o
  );

  modport slave (
    output op, funct, zero, overflow,
    input  alusel, alusrca, alusrcb, iord, memwrite, irwrite, regwrite,
           regdst, memtoreg, pcsrc, pcen, exc, exc_cause, state_o
  );

endinterface

// File: rtl/mips_mc_ctrl_alu_dec.sv
// Purpose: maps (state, funct) to the ALU select and flags an undecoded R-type funct.
// Latency: combinational.
// Backpressure: none.
// Ports: state/funct in; alusel (0010 add, 0110 sub, 1111 idle) and ill_funct out.
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] funct,
  output logic [3:0] alusel,
  output logic       ill_funct
);

  logic [3:0] funct_sel;

  // ill_funct depends only on funct so the FSM can use it regardless of state.
  always_comb begin
    funct_sel = ALUSEL_ZERO;
    ill_funct = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: begin
        funct_sel = ALUSEL_ADD;
        ill_funct = 1'b0;
      end
      FN_SUB, FN_SUBU: begin
        funct_sel = ALUSEL_SUB;
        ill_funct = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    alusel = ALUSEL_ZERO;
    case (state)
      S_FETCH, S_DECODE, S_MEMADR, S_ADDIEX: alusel = ALUSEL_ADD;
      S_BRANCH:                              alusel = ALUSEL_SUB;
      S_EXEC:                                alusel = funct_sel;
      default:                               alusel = ALUSEL_ZERO;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Purpose: Moore main-control FSM of the multicycle MIPS core, one ALU operation per state, with overflow/illegal traps.
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles; traps 4 (R/addi) or 3 (illegal op) cycles, FETCH through last state.
// Backpressure: none; datapath must act on the controls every cycle. reset_n low forces all write enables and exc to 0.
// Ports: clk, reset_n (sync, active-low), bus (master modport: op/funct/zero/overflow in, datapath controls, exc, exc_cause, state_o out).
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit TRAP_OVF = 1'b1,
  parameter bit TRAP_ILL = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  mips_mc_ctrl_if.master  bus
);

  state_t     state_q, state_d;
  state_t     dec_state;
  logic [1:0] cause_q, cause_d;
  logic [3:0] alusel;
  logic       ill_funct;

  logic       alusrca, iord, memwrite, irwrite, regwrite, regdst, memtoreg, pcen, exc;
  logic [1:0] alusrcb, pcsrc;

  // During reset the outputs show FETCH values regardless of the register,
  // which lets an aborted instruction stop driving its controls immediately.
  assign dec_state = reset_n ? state_q : S_FETCH;

  mips_alu_dec u_alu_dec (
    .state     (dec_state),
    .funct     (bus.funct),
    .alusel    (alusel),
    .ill_funct (ill_funct)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cause_q <= EXC_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Next state; cause_d only changes on transitions into EXC.
  always_comb begin
    state_d = S_FETCH;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            if (TRAP_ILL) begin
              state_d = S_EXC;
              cause_d = EXC_ILL;
            end
          end
        endcase
      end
      S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC: begin
        // Illegal funct takes priority over a simultaneous overflow.
        if (ill_funct) begin
          if (TRAP_ILL) begin
            state_d = S_EXC;
            cause_d = EXC_ILL;
          end
        end else if (TRAP_OVF && bus.overflow && fn_signed(bus.funct)) begin
          state_d = S_EXC;
          cause_d = EXC_OVF;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ADDIEX: begin
        if (TRAP_OVF && bus.overflow) begin
          state_d = S_EXC;
          cause_d = EXC_OVF;
        end else begin
          state_d = S_ADDIWB;
        end
      end
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode; the only input dependence is pcen = zero in BRANCH.
  always_comb begin
    alusrca  = 1'b0;
    alusrcb  = SRCB_REGB;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    pcsrc    = PCSRC_ALU;
    pcen     = 1'b0;
    exc      = 1'b0;
    case (dec_state)
      S_FETCH: begin
        alusrcb = SRCB_FOUR;
        irwrite = 1'b1;
        pcen    = 1'b1;
      end
      S_DECODE: alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD:  iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXEC:   alusrca = 1'b1;
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        pcsrc   = PCSRC_ALUOUT;
        pcen    = bus.zero;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = PCSRC_JUMP;
        pcen  = 1'b1;
      end
      S_EXC: begin
        exc   = 1'b1;
        pcsrc = PCSRC_VEC;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    if (!reset_n) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      exc      = 1'b0;
    end
  end

  assign bus.alusel    = alusel;
  assign bus.alusrca   = alusrca;
  assign bus.alusrcb   = alusrcb;
  assign bus.iord      = iord;
  assign bus.memwrite  = memwrite;
  assign bus.irwrite   = irwrite;
  assign bus.regwrite  = regwrite;
  assign bus.regdst    = regdst;
  assign bus.memtoreg  = memtoreg;
  assign bus.pcsrc     = pcsrc;
  assign bus.pcen      = pcen;
  assign bus.exc       = exc;
  assign bus.exc_cause = cause_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: dut0 traps on everything, dut1 has illegal-op trapping disabled.
// Stimulus pushes the hand-derived output vector for each cycle; a monitor pops and compares at negedge.
module tb_mips_mc_ctrl;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst0, rst1;

  mips_mc_ctrl_if bus0();
  mips_mc_ctrl_if bus1();

  mips_mc_ctrl #(.TRAP_OVF(1'b1), .TRAP_ILL(1'b1)) dut0 (.clk(clk), .reset_n(rst0), .bus(bus0));
  mips_mc_ctrl #(.TRAP_OVF(1'b1), .TRAP_ILL(1'b0)) dut1 (.clk(clk), .reset_n(rst1), .bus(bus1));

  always #5 clk = ~clk;

  // {state, alusel, alusrca, alusrcb, iord, memwrite, irwrite, regwrite, regdst, memtoreg, pcsrc, pcen, exc, exc_cause}
  logic [22:0] act0, act1;
  assign act0 = {bus0.state_o, bus0.alusel, bus0.alusrca, bus0.alusrcb, bus0.iord, bus0.memwrite,
                 bus0.irwrite, bus0.regwrite, bus0.regdst, bus0.memtoreg, bus0.pcsrc, bus0.pcen,
                 bus0.exc, bus0.exc_cause};
  assign act1 = {bus1.state_o, bus1.alusel, bus1.alusrca, bus1.alusrcb, bus1.iord, bus1.memwrite,
                 bus1.irwrite, bus1.regwrite, bus1.regdst, bus1.memtoreg, bus1.pcsrc, bus1.pcen,
                 bus1.exc, bus1.exc_cause};

  typedef struct {
    int          d;
    logic [22:0] v;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [22:0] pk(input logic [3:0] s, input logic [3:0] al, input logic a,
                                     input logic [1:0] b, input logic io, input logic mw,
                                     input logic irw, input logic rw, input logic rd,
                                     input logic mtr, input logic [1:0] ps, input logic pe,
                                     input logic ex, input logic [1:0] c);
    return {s, al, a, b, io, mw, irw, rw, rd, mtr, ps, pe, ex, c};
  endfunction

  // Per-state output table transcribed from the state descriptions.
  function automatic logic [22:0] spec_out(input state_t s, input logic [3:0] alx,
                                           input logic z, input logic [1:0] c);
    case (s)
      S_FETCH:  return pk(s, 4'b0010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, c);
      S_DECODE: return pk(s, 4'b0010, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, c);
      S_MEMADR: return pk(s, 4'b0010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, c);
      S_MEMRD:  return pk(s, 4'b1111, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, c);
      S_MEMWB:  return pk(s, 4'b1111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, c);
      S_MEMWR:  return pk(s, 4'b1111, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, c);
      S_EXEC:   return pk(s, alx,     1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, c);
      S_ALUWB:  return pk(s, 4'b1111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, c);
      S_BRANCH: return pk(s, 4'b0110, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, z,    1'b0, c);
      S_ADDIEX: return pk(s, 4'b0010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, c);
      S_ADDIWB: return pk(s, 4'b1111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, c);
      S_JUMP:   return pk(s, 4'b1111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, c);
      S_EXC:    return pk(s, 4'b1111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, c);
      default:  return 23'h7fffff;
    endcase
  endfunction

  // While reset_n is low: FETCH controls with all write enables and exc forced off.
  function automatic logic [22:0] rst_out(input state_t s, input logic [1:0] c);
    return pk(s, 4'b0010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, c);
  endfunction

  task automatic setin(input logic [5:0] o, input logic [5:0] f, input logic z, input logic ov);
    bus0.op = o; bus0.funct = f; bus0.zero = z; bus0.overflow = ov;
    bus1.op = o; bus1.funct = f; bus1.zero = z; bus1.overflow = ov;
  endtask

  task automatic push(input int d, input logic [22:0] v, input string nm);
    exp_t e;
    e.d = d; e.v = v; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(input string nm, input state_t s, input logic [1:0] c,
                    input logic [3:0] alx = 4'b1111, input logic z = 1'b0);
    push(0, spec_out(s, alx, z, c), nm);
    adv();
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      n_cmp++;
      if ((mon_e.d == 0 ? act0 : act1) !== mon_e.v) begin
        n_bad++;
        $display("FAIL %s dut%0d: got %h want %h", mon_e.nm, mon_e.d,
                 (mon_e.d == 0 ? act0 : act1), mon_e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b0;
    rst1 = 1'b0;
    setin(OP_SW, 6'b000000, 1'b0, 1'b0);
    adv();
    // Reset held with sw in the IR: no writes, cause cleared.
    for (int i = 0; i < 3; i++) begin
      push(0, rst_out(S_FETCH, EXC_NONE), "reset_hold");
      adv();
    end
    rst0 = 1'b0;

    // lw
    rst0 = 1'b1;
    setin(OP_LW, 6'b000000, 1'b0, 1'b0);
    ck("lw_fetch",  S_FETCH,  EXC_NONE);
    ck("lw_decode", S_DECODE, EXC_NONE);
    ck("lw_memadr", S_MEMADR, EXC_NONE);
    ck("lw_memrd",  S_MEMRD,  EXC_NONE);
    ck("lw_memwb",  S_MEMWB,  EXC_NONE);

    // beq taken
    setin(OP_BEQ, 6'b000000, 1'b0, 1'b0);
    ck("beq1_fetch",  S_FETCH,  EXC_NONE);
    ck("beq1_decode", S_DECODE, EXC_NONE);
    setin(OP_BEQ, 6'b000000, 1'b1, 1'b0);
    ck("beq1_branch", S_BRANCH, EXC_NONE, 4'b1111, 1'b1);
    // beq not taken
    setin(OP_BEQ, 6'b000000, 1'b0, 1'b0);
    ck("beq0_fetch",  S_FETCH,  EXC_NONE);
    ck("beq0_decode", S_DECODE, EXC_NONE);
    ck("beq0_branch", S_BRANCH, EXC_NONE, 4'b1111, 1'b0);

    // add with overflow traps
    setin(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
    ck("add_fetch",  S_FETCH,  EXC_NONE);
    ck("add_decode", S_DECODE, EXC_NONE);
    setin(OP_RTYPE, FN_ADD, 1'b0, 1'b1);
    ck("add_exec",   S_EXEC,   EXC_NONE, 4'b0010);
    setin(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
    ck("add_exc",    S_EXC,    EXC_OVF);

    // addu with overflow writes back
    setin(OP_RTYPE, FN_ADDU, 1'b0, 1'b0);
    ck("addu_fetch",  S_FETCH,  EXC_OVF);
    ck("addu_decode", S_DECODE, EXC_OVF);
    setin(OP_RTYPE, FN_ADDU, 1'b0, 1'b1);
    ck("addu_exec",   S_EXEC,   EXC_OVF, 4'b0010);
    setin(OP_RTYPE, FN_ADDU, 1'b0, 1'b0);
    ck("addu_aluwb",  S_ALUWB,  EXC_OVF);

    // sub without overflow
    setin(OP_RTYPE, FN_SUB, 1'b0, 1'b0);
    ck("sub_fetch",  S_FETCH,  EXC_OVF);
    ck("sub_decode", S_DECODE, EXC_OVF);
    ck("sub_exec",   S_EXEC,   EXC_OVF, 4'b0110);
    ck("sub_aluwb",  S_ALUWB,  EXC_OVF);

    // addi with overflow traps
    setin(OP_ADDI, 6'b000000, 1'b0, 1'b0);
    ck("addi_fetch",  S_FETCH,  EXC_OVF);
    ck("addi_decode", S_DECODE, EXC_OVF);
    setin(OP_ADDI, 6'b000000, 1'b0, 1'b1);
    ck("addi_ex",     S_ADDIEX, EXC_OVF);
    setin(OP_ADDI, 6'b000000, 1'b0, 1'b0);
    ck("addi_exc",    S_EXC,    EXC_OVF);

    // j
    setin(OP_J, 6'b000000, 1'b0, 1'b0);
    ck("j_fetch",  S_FETCH,  EXC_OVF);
    ck("j_decode", S_DECODE, EXC_OVF);
    ck("j_jump",   S_JUMP,   EXC_OVF);

    // illegal funct with overflow also set: illegal wins
    setin(OP_RTYPE, 6'b101010, 1'b0, 1'b0);
    ck("illfn_fetch",  S_FETCH,  EXC_OVF);
    ck("illfn_decode", S_DECODE, EXC_OVF);
    setin(OP_RTYPE, 6'b101010, 1'b0, 1'b1);
    ck("illfn_exec",   S_EXEC,   EXC_OVF, 4'b1111);
    setin(OP_RTYPE, 6'b101010, 1'b0, 1'b0);
    ck("illfn_exc",    S_EXC,    EXC_ILL);

    // addi overflow again: cause switches back to overflow
    setin(OP_ADDI, 6'b000000, 1'b0, 1'b0);
    ck("addi2_fetch",  S_FETCH,  EXC_ILL);
    ck("addi2_decode", S_DECODE, EXC_ILL);
    setin(OP_ADDI, 6'b000000, 1'b0, 1'b1);
    ck("addi2_ex",     S_ADDIEX, EXC_ILL);
    setin(OP_ADDI, 6'b000000, 1'b0, 1'b0);
    ck("addi2_exc",    S_EXC,    EXC_OVF);

    // illegal op on both: dut0 traps, dut1 treats it as a NOP
    setin(6'b111111, 6'b000000, 1'b0, 1'b0);
    rst1 = 1'b1;
    push(1, spec_out(S_FETCH, 4'b1111, 1'b0, EXC_NONE), "illop_t0_fetch");
    ck("illop_fetch", S_FETCH, EXC_OVF);
    push(1, spec_out(S_DECODE, 4'b1111, 1'b0, EXC_NONE), "illop_t0_decode");
    ck("illop_decode", S_DECODE, EXC_OVF);
    push(1, spec_out(S_FETCH, 4'b1111, 1'b0, EXC_NONE), "illop_t0_back_fetch");
    ck("illop_exc", S_EXC, EXC_ILL);

    // sw aborted by reset in MEMWR
    setin(OP_SW, 6'b000000, 1'b0, 1'b0);
    ck("sw_fetch",  S_FETCH,  EXC_ILL);
    ck("sw_decode", S_DECODE, EXC_ILL);
    ck("sw_memadr", S_MEMADR, EXC_ILL);
    rst0 = 1'b0;
    push(0, rst_out(S_MEMWR, EXC_ILL), "sw_memwr_in_reset");
    adv();
    rst0 = 1'b1;
    ck("sw_after_reset", S_FETCH, EXC_NONE);
    ck("sw_restart_decode", S_DECODE, EXC_NONE);

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
